// File: rtl/conv_mac_sequencer_if.sv
// Operand-bank and result-stream bundle for the single-MAC
// convolution sequencer.
interface conv_mac_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int RES_W  = 8
);
  logic              run;
  logic [3:0]        a_addr;
  logic [3:0]        b_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [RES_W-1:0]  result;
  logic [ACC_W-1:0]  result_full;
  logic              result_valid;
  logic [1:0]        result_idx;
  logic              busy;
  logic              done;
  logic [2:0]        current_state;

  modport master (
    input  run, a_data, b_data,
    output a_addr, b_addr, result, result_full,
    output result_valid, result_idx, busy, done,
    output current_state
  );

  modport slave (
    output run, a_data, b_data,
    input  a_addr, b_addr, result, result_full,
    input  result_valid, result_idx, busy, done,
    input  current_state
  );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Walks one shared MAC through a 3x3 kernel over a 4x4 input,
// emitting the four 2x2 output points in row-major order.
module conv_mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int RES_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_mac_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_STORE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_idx;
  logic [1:0]         w_idx_nxt;
  logic [3:0]         r_tap;
  logic [3:0]         w_tap_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_load;
  logic [RES_W-1:0]   r_result;
  logic [ACC_W-1:0]   r_result_full;
  logic [1:0]         r_result_idx;
  logic [1:0]         w_i;
  logic [1:0]         w_j;
  logic [1:0]         w_row;
  logic [1:0]         w_col;
  logic [2*DATA_W-1:0] w_prod;

  always_comb begin
    w_i = 2'd0;
    w_j = 2'd0;
    unique case (r_tap)
      4'd1:    w_j = 2'd1;
      4'd2:    w_j = 2'd2;
      4'd3:    w_i = 2'd1;
      4'd4:    {w_i, w_j} = 4'b0101;
      4'd5:    {w_i, w_j} = 4'b0110;
      4'd6:    w_i = 2'd2;
      4'd7:    {w_i, w_j} = 4'b1001;
      4'd8:    {w_i, w_j} = 4'b1010;
      default: {w_i, w_j} = 4'b0000;
    endcase
  end

  assign w_row = {1'b0, r_idx[1]} + w_i;
  assign w_col = {1'b0, r_idx[0]} + w_j;
  assign w_prod = bus.a_data * bus.b_data;

  assign bus.a_addr = {w_row, w_col};
  assign bus.b_addr = r_tap;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tap_nxt   = r_tap;
    w_acc_nxt   = r_acc;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_state_nxt = S_MAC;
          w_idx_nxt   = 2'd0;
          w_tap_nxt   = 4'd0;
        end
      end
      S_MAC: begin
        w_acc_nxt = (r_tap == 4'd0 ? '0 : r_acc)
                  + ACC_W'(w_prod);
        if (r_tap == 4'd8) begin
          w_tap_nxt   = 4'd0;
          w_state_nxt = S_STORE;
          w_load      = 1'b1;
        end else begin
          w_tap_nxt = r_tap + 4'd1;
        end
      end
      S_STORE: begin
        if (r_idx == 2'd3) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = S_MAC;
        end
      end
      S_DONE: begin
        if (!bus.run) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers load as STORE is entered so they are
  // already valid during the STORE strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_tap         <= 4'd0;
      r_acc         <= '0;
      r_result      <= '0;
      r_result_full <= '0;
      r_result_idx  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tap   <= w_tap_nxt;
      r_acc   <= w_acc_nxt;
      if (w_load) begin
        r_result      <= w_acc_nxt[RES_W-1:0];
        r_result_full <= w_acc_nxt;
        r_result_idx  <= r_idx;
      end
    end
  end

  assign bus.result        = r_result;
  assign bus.result_full   = r_result_full;
  assign bus.result_idx    = r_result_idx;
  assign bus.result_valid  = (r_state == S_STORE);
  assign bus.busy          = (r_state == S_MAC)
                           || (r_state == S_STORE);
  assign bus.done          = (r_state == S_DONE);
  assign bus.current_state = r_state;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Randomised and directed checks of the convolution sequencer
// against a plain-arithmetic convolution model.
module tb_conv_mac_sequencer;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_mac_sequencer_if #(
    .DATA_W(DW), .ACC_W(AW), .RES_W(RW)
  ) bus ();

  conv_mac_sequencer #(
    .DATA_W(DW), .ACC_W(AW), .RES_W(RW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int ma [4][4];
  int mb [3][3];
  int exp_full [4];
  int got_res [4];
  int n_chk = 0;
  int n_fail = 0;
  int spec_res [4] = '{111, 99, 105, 146};

  always_comb begin
    bus.a_data = 8'(ma[bus.a_addr[3:2]][bus.a_addr[1:0]]);
    if (bus.b_addr < 4'd9)
      bus.b_data = 8'(mb[bus.b_addr / 3][bus.b_addr % 3]);
    else
      bus.b_data = 8'd0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model();
    for (int k = 0; k < 4; k++) begin
      int s;
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += ma[k/2 + i][k%2 + j] * mb[i][j];
      exp_full[k] = s;
    end
  endfunction

  task automatic load_spec();
    ma = '{'{3,1,6,5}, '{7,5,2,7}, '{7,10,8,9}, '{1,3,2,10}};
    mb = '{'{3,1,4}, '{0,5,1}, '{0,1,5}};
  endtask

  task automatic go_idle();
    bus.run = 1'b0;
    step();
    n_chk++;
    if (bus.current_state !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_entry state got %0d want 0",
               bus.current_state);
    end
  endtask

  task automatic run_check(input string nm, input int drop_t);
    int k, tp, ea;
    model();
    bus.run = 1'b1;
    step();
    for (int t = 0; t < 40; t++) begin
      k = t / 10;
      tp = t % 10;
      n_chk++;
      if (bus.result_valid !== (tp == 9) || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s valid/busy t=%0d got %b/%b want %b/1",
                 nm, t, bus.result_valid, bus.busy, tp == 9);
      end
      if (tp == 9) begin
        got_res[k] = int'(bus.result);
        n_chk++;
        if (bus.result_idx !== 2'(k)
            || bus.result_full !== AW'(exp_full[k])
            || bus.result !== RW'(exp_full[k])) begin
          n_fail++;
          $display("FAIL %s point%0d got idx=%0d full=%0d res=%0d want %0d/%0d/%0d",
                   nm, k, bus.result_idx, bus.result_full, bus.result,
                   k, exp_full[k], exp_full[k] % 256);
        end
      end else begin
        ea = 4 * (k/2 + tp/3) + (k%2 + tp%3);
        n_chk++;
        if (bus.a_addr !== 4'(ea) || bus.b_addr !== 4'(tp)) begin
          n_fail++;
          $display("FAIL %s addr t=%0d got a=%0d b=%0d want a=%0d b=%0d",
                   nm, t, bus.a_addr, bus.b_addr, ea, tp);
        end
      end
      if (t == drop_t) bus.run = 1'b0;
      step();
    end
    n_chk++;
    if (bus.done !== 1'b1 || bus.current_state !== 3'd3
        || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done got done=%b st=%0d want 1/3",
               nm, bus.done, bus.current_state);
    end
  endtask

  task automatic check_spec_results(input string nm);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (got_res[k] !== spec_res[k]) begin
        n_fail++;
        $display("FAIL %s c%0d got %0d want %0d",
                 nm, k, got_res[k], spec_res[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.run = 1'b0;
    step();
    step();
    n_chk++;
    if (bus.result !== '0 || bus.result_full !== '0
        || bus.result_valid !== 1'b0 || bus.result_idx !== 2'd0
        || bus.busy !== 1'b0 || bus.done !== 1'b0
        || bus.current_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset outputs got st=%0d busy=%b done=%b v=%b want all 0",
               bus.current_state, bus.busy, bus.done, bus.result_valid);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    load_spec();
    go_idle();
    run_check("basic", -1);
    check_spec_results("basic");
  endtask

  task automatic test_hold_done();
    for (int c = 0; c < 5; c++) begin
      step();
      n_chk++;
      if (bus.done !== 1'b1 || bus.result_valid !== 1'b0
          || bus.current_state !== 3'd3) begin
        n_fail++;
        $display("FAIL hold_done c=%0d got done=%b v=%b st=%0d want 1/0/3",
                 c, bus.done, bus.result_valid, bus.current_state);
      end
    end
    go_idle();
    n_chk++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_done drop got done=%b want 0", bus.done);
    end
    run_check("rerun", -1);
    check_spec_results("rerun");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ma[i][j] = 255;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mb[i][j] = 255;
    go_idle();
    run_check("sat", -1);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (exp_full[k] != 585225 || got_res[k] !== 9) begin
        n_fail++;
        $display("FAIL sat c%0d got %0d/%0d want 585225/9",
                 k, exp_full[k], got_res[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) ma[i][j] = int'($urandom_range(0, 255));
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) mb[i][j] = int'($urandom_range(0, 255));
      go_idle();
      run_check("rand", -1);
    end
  endtask

  task automatic test_drop_run();
    load_spec();
    go_idle();
    run_check("drop", 12);
    check_spec_results("drop");
  endtask

  task automatic test_reset_mid();
    int nv;
    load_spec();
    go_idle();
    bus.run = 1'b1;
    step();
    nv = 0;
    for (int t = 0; t < 24; t++) begin
      if (bus.result_valid === 1'b1) nv++;
      step();
    end
    n_chk++;
    if (nv != 2 || bus.current_state !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_mid pre got nv=%0d st=%0d want 2/1",
               nv, bus.current_state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.run = 1'b0;
    n_chk++;
    if (bus.result !== '0 || bus.result_full !== '0
        || bus.result_valid !== 1'b0 || bus.result_idx !== 2'd0
        || bus.busy !== 1'b0 || bus.done !== 1'b0
        || bus.current_state !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid outputs got st=%0d busy=%b v=%b full=%0d want all 0",
               bus.current_state, bus.busy, bus.result_valid, bus.result_full);
    end
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.result_valid === 1'b1) nv++;
    end
    n_chk++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL rst_mid stray valid got %0d want 0", nv);
    end
    run_check("after_rst", -1);
    check_spec_results("after_rst");
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b0;
    load_spec();
    test_reset();
    test_basic();
    test_hold_done();
    test_saturate();
    test_random();
    test_drop_run();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
